imem_arbiter: RTL

- Shares the single-port, word-organised instruction memory between two requesters:
  - the core fetch stage (read-only);
  - the program loader (write-only, used to fill program images at run time instead of file preload).
- Arbitrates per cycle, drives the memory's synchronous port, returns fetch data one cycle after grant, and flags misaligned or out-of-range accesses.
- Sits between IF stage / loader and the IMEM storage array.

---
 rtl/imem_pkg.sv | 10 +
 rtl/imem_arbiter_if.sv | 33 +++
 rtl/imem_starve_ctr.sv | 25 ++
 rtl/imem_arbiter.sv | 55 +++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared default widths and the address fault rule for the instruction-memory arbiter
package imem_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_WORD_ADDR_BITS = 18;
  localparam int DEF_STARVE_LIMIT = 4;
  function automatic logic addr_fault(input logic [63:0] addr, input int word_bits);
    return (addr[1:0] != 2'b00) || ((addr >> (word_bits + 2)) != 64'd0);
  endfunction
endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and memory-port signals shared by the arbiter and its neighbours
interface imem_arbiter_if import imem_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WORD_ADDR_BITS = DEF_WORD_ADDR_BITS
);
  logic if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic if_gnt;
  logic if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic if_fault;
  logic ld_req;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_wdata;
  logic ld_gnt;
  logic ld_err;
  logic mem_en;
  logic mem_we;
  logic [WORD_ADDR_BITS-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport slave (
    input if_req, if_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_fault, ld_gnt, ld_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
    input if_gnt, if_rvalid, if_rdata, if_fault, ld_gnt, ld_err,
    input mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_starve_ctr.sv
// imem_starve_ctr: loader-first grant select with a saturating counter that lets a starved fetch through
module imem_starve_ctr import imem_pkg::*; #(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic ld_req,
  output logic if_gnt,
  output logic ld_gnt
);
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  logic [CW-1:0] cnt;
  logic fetch_pri;
  // Loader wins contention until fetch has waited STARVE_LIMIT grants; nothing is granted in reset
  always_comb begin
    fetch_pri = cnt == CW'(STARVE_LIMIT);
    ld_gnt = !rst && ld_req && (!if_req || !fetch_pri);
    if_gnt = !rst && if_req && !ld_gnt;
  end
  // Count loader grants that made fetch wait; the limit is never exceeded because fetch then wins
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= (ld_gnt && if_req) ? cnt + CW'(1) : '0;
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port instruction memory between the fetch stage and the program loader
module imem_arbiter import imem_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WORD_ADDR_BITS = DEF_WORD_ADDR_BITS,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic clk,
  input logic rst,
  imem_arbiter_if.slave bus
);
  logic if_g, ld_g, if_flt, ld_flt, use_ld, last_ld, rd_ok, rvalid, fault, err;
  logic [ADDR_WIDTH-1:0] if_a, ld_a;
  imem_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk),
    .rst(rst),
    .if_req(bus.if_req),
    .ld_req(bus.ld_req),
    .if_gnt(if_g),
    .ld_gnt(ld_g)
  );
  // Fault-check both candidates; the idle port keeps pointing at whoever was granted last
  always_comb begin
    if_a = bus.if_addr;
    ld_a = bus.ld_addr;
    if_flt = addr_fault(64'(if_a), WORD_ADDR_BITS);
    ld_flt = addr_fault(64'(ld_a), WORD_ADDR_BITS);
    use_ld = ld_g || (!if_g && last_ld);
  end
  assign bus.if_gnt = if_g;
  assign bus.ld_gnt = ld_g;
  assign bus.mem_en = (if_g && !if_flt) || (ld_g && !ld_flt);
  assign bus.mem_we = ld_g && !ld_flt;
  assign bus.mem_addr = rst ? '0 : use_ld ? ld_a[WORD_ADDR_BITS+1:2] : if_a[WORD_ADDR_BITS+1:2];
  assign bus.mem_wdata = rst ? '0 : bus.ld_wdata;
  assign bus.if_rvalid = rvalid;
  assign bus.if_fault = fault;
  assign bus.if_rdata = rd_ok ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
  assign bus.ld_err = err;
  // One-cycle response pipeline: remember what was granted so the next cycle can report it
  always_ff @(posedge clk)
    if (rst) begin
      rvalid <= 1'b0;
      fault <= 1'b0;
      rd_ok <= 1'b0;
      err <= 1'b0;
      last_ld <= 1'b0;
    end else begin
      rvalid <= if_g;
      fault <= if_g && if_flt;
      rd_ok <= if_g && !if_flt;
      err <= ld_g && ld_flt;
      if (if_g || ld_g) last_ld <= ld_g;
    end
endmodule
